// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction ROM address, captures
// {pc, inst} pairs into a small FIFO and presents the head entry to decode.
// Branch and flush redirects empty the FIFO and reload the fetch PC.
// Optional feature macro: FETCH_MISALIGN_EXC_EN (misaligned redirect flag).
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ce_o,
    output logic [31:0] pc_o,
    input  logic [31:0] inst_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        id_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        misalign_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic          ce_q;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];

    logic          redirect_s;
    logic          pop_s;
    logic          push_s;
    logic [31:0]   target_raw_s;
    logic [31:0]   target_s;

    // Redirect target selection: flush wins over branch.
    always_comb begin
        redirect_s = flush_i || branch_flag_i;
        if (flush_i) begin
            target_raw_s = new_pc_i;
        end else begin
            target_raw_s = branch_target_i;
        end
`ifdef FETCH_MISALIGN_EXC_EN
        target_s = target_raw_s;
`else
        target_s = target_raw_s & 32'hFFFF_FFFC;
`endif
    end

    // Misaligned-redirect flag: sticky until a flush reloads the PC.
    always_comb begin
        misalign_d = misalign_q;
`ifdef FETCH_MISALIGN_EXC_EN
        if (flush_i) begin
            misalign_d = (target_s[1:0] != 2'b00);
        end else if (branch_flag_i) begin
            misalign_d = misalign_q || (target_s[1:0] != 2'b00);
        end else begin
            misalign_d = misalign_q;
        end
`else
        misalign_d = 1'b0;
`endif
    end

    // Handshake decode: redirect cancels both pop and push; a pop frees a slot for the push.
    always_comb begin
        pop_s  = (count_q != CNT_ZERO) && id_ready_i && !redirect_s;
        push_s = ce_q && !redirect_s && !misalign_q &&
                 ((count_q < DEPTH_C) || pop_s);
    end

    // Next-state for fetch PC, FIFO pointers and occupancy.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (redirect_s) begin
            pc_d    = target_s;
            count_d = CNT_ZERO;
            head_d  = PTR_ZERO;
            tail_d  = PTR_ZERO;
        end else begin
            if (push_s) begin
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + PTR_ONE;
            end else begin
                pc_d   = pc_q;
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q       <= 1'b0;
            pc_q       <= RESET_PC;
            count_q    <= CNT_ZERO;
            head_q     <= PTR_ZERO;
            tail_q     <= PTR_ZERO;
            misalign_q <= 1'b0;
        end else begin
            ce_q       <= 1'b1;
            pc_q       <= pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            misalign_q <= misalign_d;
        end
    end

    // FIFO storage: cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= 32'h0000_0000;
                inst_mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_q[tail_q]   <= pc_q;
            inst_mem_q[tail_q] <= inst_i;
        end
    end

    assign ce_o       = ce_q;
    assign pc_o       = pc_q;
    assign if_valid_o = (count_q != CNT_ZERO);
    assign if_inst_o  = inst_mem_q[head_q];
    assign if_pc_o    = pc_mem_q[head_q];
    assign misalign_o = misalign_q;

endmodule
